// File: rtl/qrs_pkg.sv
// qrs_pkg
// Shared types and arithmetic helpers for the QRS threshold controller.
//   qrs_state_t    : controller state encoding
//   QRS_DATA_WIDTH : default sample / threshold width
//   sat_clip       : clamp a value to a signed w-bit range
//   ewma_step      : cur + ((tgt - cur) >>> sh), the 1/2^sh running estimate step
//   thr_calc       : npk + ((spk - npk) >>> 2), saturated to w bits
package qrs_pkg;

   typedef enum logic [1:0] {
      ST_LEARN   = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_QRS_WIN = 2'd2,
      ST_REFRACT = 2'd3
   } qrs_state_t;

   localparam int QRS_DATA_WIDTH = 11;

   function automatic int sat_clip(input int v, input int w);
      int hi;
      int lo;
      hi = (1 <<< (w - 1)) - 1;
      lo = -(1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int ewma_step(input int cur, input int tgt, input int sh);
      return cur + ((tgt - cur) >>> sh);
   endfunction

   // Evaluated at 32 bits, which covers the DATA_WIDTH+2 intermediate range.
   function automatic int thr_calc(input int spk, input int npk, input int w);
      return sat_clip(npk + ((spk - npk) >>> 2), w);
   endfunction

endpackage

// File: rtl/counter_fsm.sv
// counter_fsm
// Down-counting window timer. A start pulse loads MAX_VAL and raises o_active
// on the same edge; o_active then stays high for exactly MAX_VAL ce ticks.
//   i_clk    : system clock
//   i_nrst   : asynchronous active-low reset
//   i_ce     : count enable
//   i_start  : one-clock load pulse
//   o_active : window active (registered)
//   o_last   : high on the ce that terminates the window
module counter_fsm #(
   parameter int MAX_VAL = 72
) (
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_ce,
   input  logic i_start,
   output logic o_active,
   output logic o_last
);

   localparam int CW = $clog2(MAX_VAL + 1);

   logic [CW-1:0] cnt;

   assign o_last = o_active && i_ce && (cnt == CW'(1));

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cnt      <= '0;
         o_active <= 1'b0;
      end else if (i_start) begin
         cnt      <= CW'(MAX_VAL);
         o_active <= 1'b1;
      end else if (i_ce && o_active) begin
         if (cnt == CW'(1)) begin
            cnt      <= '0;
            o_active <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/qrs_threshold_ctrl.sv
// qrs_threshold_ctrl
// Adaptive threshold / window controller for the QRS detector. Learns initial
// signal and noise levels, then tracks the peak in each QRS window and updates
// running signal (spk) and noise (npk) estimates, emitting one R-peak event per
// accepted window with its amplitude and RR interval.
//   i_clk, i_nrst              : clock, asynchronous active-low reset
//   i_ce                       : sample-rate enable
//   i_signal_in                : filtered ECG sample (signed)
//   i_qrs_win_active           : QRS window flag from the detector
//   o_threshold                : detection threshold
//   o_refractory_win_active    : refractory window active
//   o_qrs_search_en            : detector search enable
//   o_peak_valid               : one-clock R-peak event
//   o_peak_value, o_rr_interval: peak amplitude and RR interval of last event
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_LEARN   | collect max of first LEARN_LEN samples to seed spk/npk
// ST_SEARCH  | detector enabled, track noise max, wait for a QRS window
// ST_QRS_WIN | track peak inside the window, update estimates on exit
// ST_REFRACT | refractory timer running, window flag ignored
module qrs_threshold_ctrl
   import qrs_pkg::*;
#(
   parameter int DATA_WIDTH  = QRS_DATA_WIDTH,
   parameter int LEARN_LEN   = 360,
   parameter int REFRACT_LEN = 72,
   parameter int RR_WIDTH    = 12
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  logic                         i_ce,
   input  logic signed [DATA_WIDTH-1:0] i_signal_in,
   input  logic                         i_qrs_win_active,
   output logic signed [DATA_WIDTH-1:0] o_threshold,
   output logic                         o_refractory_win_active,
   output logic                         o_qrs_search_en,
   output logic                         o_peak_valid,
   output logic signed [DATA_WIDTH-1:0] o_peak_value,
   output logic [RR_WIDTH-1:0]          o_rr_interval
);

   localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam int                           LCW   = $clog2(LEARN_LEN + 1);
   localparam logic [RR_WIDTH-1:0]          RR_MAX = '1;

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   qrs_state_t                   state;
   logic [LCW-1:0]               learn_cnt;
   logic signed [DATA_WIDTH-1:0] learn_max;
   logic signed [DATA_WIDTH-1:0] noise_max;
   logic signed [DATA_WIDTH-1:0] peak_max;
   logic signed [DATA_WIDTH-1:0] spk;
   logic signed [DATA_WIDTH-1:0] npk;
   logic                         thr_upd;
   logic [RR_WIDTH-1:0]          rr_cnt;
   logic [RR_WIDTH-1:0]          rr_pending;
   logic                         seen_qrs;

   logic signed [DATA_WIDTH-1:0] learn_new;
   logic signed [DATA_WIDTH-1:0] peak_new;
   logic [RR_WIDTH-1:0]          rr_inc;
   logic                         refr_start;
   logic                         refr_last;

   always_comb begin
      learn_new = smax(learn_max, i_signal_in);
      // The exit sample also belongs to the window, so a one-tick window
      // still sees both of its samples.
      peak_new  = smax(peak_max, i_signal_in);
      rr_inc    = (rr_cnt == RR_MAX) ? rr_cnt : rr_cnt + 1'b1;
   end

   // Combinational start so the timer's active output rises on the same edge
   // that moves the FSM into refractory.
   assign refr_start = (state == ST_QRS_WIN) && i_ce && !i_qrs_win_active;

   counter_fsm #(
      .MAX_VAL (REFRACT_LEN)
   ) u_refract (
      .i_clk    (i_clk),
      .i_nrst   (i_nrst),
      .i_ce     (i_ce),
      .i_start  (refr_start),
      .o_active (o_refractory_win_active),
      .o_last   (refr_last)
   );

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state           <= ST_LEARN;
         learn_cnt       <= '0;
         learn_max       <= S_MIN;
         noise_max       <= S_MIN;
         peak_max        <= S_MIN;
         spk             <= '0;
         npk             <= '0;
         thr_upd         <= 1'b0;
         rr_cnt          <= '0;
         rr_pending      <= '0;
         seen_qrs        <= 1'b0;
         o_threshold     <= S_MAX;
         o_qrs_search_en <= 1'b0;
         o_peak_valid    <= 1'b0;
         o_peak_value    <= '0;
         o_rr_interval   <= '0;
      end else begin
         o_peak_valid <= 1'b0;
         thr_upd      <= 1'b0;
         if (thr_upd) begin
            o_threshold <= DATA_WIDTH'(thr_calc(int'(spk), int'(npk), DATA_WIDTH));
         end
         if (i_ce) begin
            if (state != ST_LEARN) begin
               rr_cnt <= rr_inc;
            end
            case (state)
               ST_LEARN: begin
                  learn_max <= learn_new;
                  learn_cnt <= learn_cnt + 1'b1;
                  if (learn_cnt == LCW'(LEARN_LEN - 1)) begin
                     spk             <= learn_new >>> 1;
                     npk             <= learn_new >>> 3;
                     thr_upd         <= 1'b1;
                     state           <= ST_SEARCH;
                     o_qrs_search_en <= 1'b1;
                  end
               end
               ST_SEARCH: begin
                  if (i_qrs_win_active) begin
                     // The window's opening sample is signal, not noise.
                     state           <= ST_QRS_WIN;
                     o_qrs_search_en <= 1'b0;
                     peak_max        <= i_signal_in;
                     rr_cnt          <= '0;
                     rr_pending      <= seen_qrs ? rr_inc : '0;
                     seen_qrs        <= 1'b1;
                  end else begin
                     noise_max <= smax(noise_max, i_signal_in);
                  end
               end
               ST_QRS_WIN: begin
                  if (i_qrs_win_active) begin
                     peak_max <= peak_new;
                  end else begin
                     spk <= DATA_WIDTH'(sat_clip(ewma_step(int'(spk), int'(peak_new), 3), DATA_WIDTH));
                     npk <= DATA_WIDTH'(sat_clip(ewma_step(int'(npk), int'(noise_max), 3), DATA_WIDTH));
                     thr_upd       <= 1'b1;
                     o_peak_value  <= peak_new;
                     o_rr_interval <= rr_pending;
                     o_peak_valid  <= 1'b1;
                     noise_max     <= S_MIN;
                     state         <= ST_REFRACT;
                  end
               end
               ST_REFRACT: begin
                  if (refr_last) begin
                     state           <= ST_SEARCH;
                     o_qrs_search_en <= 1'b1;
                  end
               end
               default: state <= ST_LEARN;
            endcase
         end
      end
   end

endmodule

// File: doc/qrs_threshold_ctrl.md
# qrs_threshold_ctrl

Adaptive-threshold and window controller that drives the control inputs of the QRS detector: it supplies the detection threshold, the refractory window and the search enable. It consumes the detector's QRS-window flag and the same filtered ECG samples. It measures the peak inside each QRS window and updates signal/noise estimates Pan-Tompkins style. It emits one R-peak event per accepted QRS with peak amplitude and RR interval.

## Interface
- DATA_WIDTH, 11, signed sample / threshold width
- LEARN_LEN, 360, ce ticks of initial learning phase (≥2)
- REFRACT_LEN, 72, ce ticks of refractory window after each QRS window ends (≥1)
- RR_WIDTH, 12, width of RR interval counter

- i_clk  in  1  system clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_ce  in  1  sample-rate clock enable; all state updates qualified by it
- i_signal_in  in  DATA_WIDTH signed  filtered ECG sample, valid on ce cycles
- i_qrs_win_active  in  1  QRS window flag from detector
- o_threshold  out  DATA_WIDTH signed  detection threshold
- o_refractory_win_active  out  1  refractory window active
- o_qrs_search_en  out  1  detector search enable
- o_peak_valid  out  1  one-clock pulse: R-peak event
- o_peak_value  out  DATA_WIDTH signed  max sample in last QRS window
- o_rr_interval  out  RR_WIDTH  ce ticks between last two QRS window starts, saturating

## Operation
- FSM states: LEARN, SEARCH, QRS_WIN, REFRACT.
- Reset: state LEARN; o_threshold = max positive (2^(DATA_WIDTH-1)-1); o_refractory_win_active=0; o_qrs_search_en=0; o_peak_valid=0; o_peak_value=0; o_rr_interval=0; spk=npk=0; learn counter and RR counter 0.
- LEARN: on each ce, learn_max <= max(learn_max, sample), learn counter increments. On the LEARN_LEN-th ce: spk <= learn_max>>>1, npk <= learn_max>>>3, threshold computed from them, go SEARCH.
- Threshold rule: thr = npk + ((spk − npk)>>>2), all in DATA_WIDTH+2 signed, saturated to DATA_WIDTH range. Updated on the cycle after every spk/npk change.
- SEARCH: o_qrs_search_en=1. On each ce, noise_max <= max(noise_max, sample). On a ce with i_qrs_win_active=1 go QRS_WIN. In the same step, latch o_rr_interval <= rr_cnt (the first QRS after LEARN reports 0), clear rr_cnt, and start peak_max with the current sample.
- QRS_WIN: o_qrs_search_en=0. peak_max <= max(peak_max, sample) per ce. On the first ce with i_qrs_win_active=0 do the following, then go REFRACT:
  - spk <= spk + ((peak_max − spk)>>>3);
  - npk <= npk + ((noise_max − npk)>>>3);
  - o_peak_value <= peak_max; pulse o_peak_valid;
  - clear noise_max to min negative.
- REFRACT: o_refractory_win_active=1, o_qrs_search_en=0. Refractory counter runs REFRACT_LEN ce ticks, then go SEARCH. i_qrs_win_active asserting in REFRACT is ignored.
- rr_cnt increments on every ce outside LEARN, saturating at 2^RR_WIDTH−1.
- Without i_ce nothing changes, except that o_peak_valid drops after one clock.

## Timing
- All outputs registered.
- Detector latency is 1 clock from threshold crossing to ctr_start, plus counter start; this block only reacts to i_qrs_win_active.
- o_peak_valid: exactly one i_clk cycle, on the clock after the ce where QRS_WIN exits; o_peak_value and o_rr_interval are stable from that cycle until the next event.
- o_threshold reflects new spk/npk 2 clocks after the QRS_WIN exit ce.
- o_refractory_win_active rises on the same clock edge as the transition to REFRACT; it falls after exactly REFRACT_LEN ce ticks, together with o_qrs_search_en rising.
- Window of 1 ce tick (active for only one ce): QRS_WIN is entered and exited on consecutive ce; the peak is the max of both samples.
- Asynchronous reset mid-operation returns to LEARN immediately; the learning phase is redone.

## Structure
- Shared package qrs_pkg: state enum typedef, saturating-add/shift helper functions, DATA_WIDTH default constant.
- Refractory timer: instantiate existing counter_fsm (MAX_VAL=REFRACT_LEN), started by a one-clock pulse on entry to REFRACT; o_active drives o_refractory_win_active.
- Everything else in one module.

## Test plan
- Learning: LEARN_LEN=8, samples ramping 0..400 -> after 8th ce, spk=200, npk=50, o_threshold=87, o_qrs_search_en=1.
- Single QRS: from the above state, noise max 60, window with peak 600 -> o_peak_valid pulse, o_peak_value=600, spk=250, npk=51, o_threshold=100.
- Refractory: REFRACT_LEN=72 -> o_refractory_win_active high exactly 72 ce ticks; window pulses inside it ignored, no o_peak_valid.
- RR: windows starting 300 ce apart -> second event o_rr_interval=300; gap >4095 with RR_WIDTH=12 -> 4095.
- Sparse ce (1 in 4 clocks): same numerical results as dense ce; o_peak_valid still exactly one clock wide.
- Reset asserted during QRS_WIN -> all outputs at reset values, state LEARN, no o_peak_valid.
